// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson counter: direction encodings and
// combinational helpers for step-index decode and legal-code detection.
package johnson_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Helpers take a zero-extended ring so they serve every WIDTH up to this bound.
  localparam int unsigned MaxWidth = 64;

  function automatic int unsigned johnson_idx(input logic [MaxWidth-1:0] q,
                                              input int unsigned         width);
    int unsigned pop;
    pop = 0;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      if (i < width) pop += {31'b0, q[i]};
    end
    if (q == '0)     return 0;
    else if (q[0])   return pop;
    else             return 2 * width - pop;
  endfunction

  function automatic logic johnson_legal(input logic [MaxWidth-1:0] q,
                                         input int unsigned         width);
    int unsigned edges;
    edges = 0;
    for (int unsigned i = 0; i + 1 < MaxWidth; i++) begin
      if (i + 1 < width) edges += {31'b0, q[i] ^ q[i+1]};
    end
    return edges <= 1;
  endfunction

endpackage

// File: rtl/timebase_tick.sv
// Prescaler producing a single-cycle step enable every PRESCALE enabled clk cycles.
module timebase_tick #(
  parameter int unsigned PRESCALE = 16777216
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clear,
  output logic tick_o
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PRESCALE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Combinational strobe: the ring consumes it on the same edge the counter wraps.
  assign tick_o = en && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/johnson_counter_param.sv
// Parametrised up/down Johnson counter stepped by an internal prescaler, with
// registered index, wrap and illegal-state recovery flags.
module johnson_counter_param
  import johnson_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 16777216
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          en,
  input  logic                          dir,
  input  logic                          clear,
  output logic [WIDTH-1:0]              q,
  output logic [$clog2(2*WIDTH)-1:0]    step_idx,
  output logic                          tick,
  output logic                          wrap,
  output logic                          fault
);

  localparam int unsigned IdxW    = $clog2(2 * WIDTH);
  localparam int unsigned SeqLast = 2 * WIDTH - 1;

  logic [WIDTH-1:0] q_q, q_d;
  logic [IdxW-1:0]  step_idx_q, step_idx_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             fault_q, fault_d;
  logic             step;
  int unsigned      idx_cur;
  logic             legal_cur;

  timebase_tick #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .clear   (clear),
    .tick_o  (step)
  );

  assign idx_cur   = johnson_idx(MaxWidth'(q_q), WIDTH);
  assign legal_cur = johnson_legal(MaxWidth'(q_q), WIDTH);

  always_comb begin
    q_d     = q_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    fault_d = 1'b0;
    if (clear) begin
      q_d = '0;
    end else if (step) begin
      tick_d = 1'b1;
      if (!legal_cur) begin
        q_d     = '0;
        fault_d = 1'b1;
      end else if (dir == DIR_UP) begin
        q_d    = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
        wrap_d = (idx_cur == SeqLast);
      end else begin
        q_d    = {~q_q[0], q_q[WIDTH-1:1]};
        wrap_d = (idx_cur == 0);
      end
    end
    // Index follows the next ring value so both register on the same edge.
    step_idx_d = IdxW'(johnson_idx(MaxWidth'(q_d), WIDTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q        <= '0;
      step_idx_q <= '0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      q_q        <= q_d;
      step_idx_q <= step_idx_d;
      tick_q     <= tick_d;
      wrap_q     <= wrap_d;
      fault_q    <= fault_d;
    end
  end

  assign q        = q_q;
  assign step_idx = step_idx_q;
  assign tick     = tick_q;
  assign wrap     = wrap_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_johnson_counter_param.sv
// Directed bench: instance A is WIDTH=4/PRESCALE=1, instance B is WIDTH=5/PRESCALE=3.
module tb_johnson_counter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, a_en, a_dir, a_clear;
  logic [3:0] a_q;
  logic [2:0] a_idx;
  logic       a_tick, a_wrap, a_fault;

  logic       b_rst_n, b_en, b_dir, b_clear;
  logic [4:0] b_q;
  logic [3:0] b_idx;
  logic       b_tick, b_wrap, b_fault;

  int checks   = 0;
  int failures = 0;

  johnson_counter_param #(.WIDTH(4), .PRESCALE(1)) dut_a (
    .clk      (clk),
    .reset_n  (a_rst_n),
    .en       (a_en),
    .dir      (a_dir),
    .clear    (a_clear),
    .q        (a_q),
    .step_idx (a_idx),
    .tick     (a_tick),
    .wrap     (a_wrap),
    .fault    (a_fault)
  );

  johnson_counter_param #(.WIDTH(5), .PRESCALE(3)) dut_b (
    .clk      (clk),
    .reset_n  (b_rst_n),
    .en       (b_en),
    .dir      (b_dir),
    .clear    (b_clear),
    .q        (b_q),
    .step_idx (b_idx),
    .tick     (b_tick),
    .wrap     (b_wrap),
    .fault    (b_fault)
  );

  logic [3:0] up_q   [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                             4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [2:0] up_idx [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
  logic [3:0] dn_q   [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
  logic [2:0] dn_idx [4] = '{3'd7, 3'd6, 3'd5, 3'd4};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic [4:0] eq, input logic [3:0] ei,
                       input logic et);
    chk({tag, "_q"}, 32'(b_q), 32'(eq));
    chk({tag, "_idx"}, 32'(b_idx), 32'(ei));
    chk({tag, "_tick"}, 32'(b_tick), 32'(et));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst_n = 1'b0; a_en = 1'b0; a_dir = 1'b1; a_clear = 1'b0;
    b_rst_n = 1'b0; b_en = 1'b0; b_dir = 1'b1; b_clear = 1'b0;
    edge1();
    edge1();
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    chk("rst_q", 32'(a_q), 32'h0);
    chk("rst_idx", 32'(a_idx), 32'h0);
    chk("rst_flags", {29'b0, a_tick, a_wrap, a_fault}, 32'h0);

    // A: up count through one full cycle
    a_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      edge1();
      chk($sformatf("up%0d_q", i), 32'(a_q), 32'(up_q[i]));
      chk($sformatf("up%0d_idx", i), 32'(a_idx), 32'(up_idx[i]));
      chk($sformatf("up%0d_wrap", i), 32'(a_wrap), (i == 7) ? 32'd1 : 32'd0);
      chk($sformatf("up%0d_tick", i), 32'(a_tick), 32'd1);
    end

    // A: down count from reset
    a_en = 1'b0;
    a_rst_n = 1'b0;
    #1;
    a_rst_n = 1'b1;
    a_dir = 1'b0;
    a_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      edge1();
      chk($sformatf("dn%0d_q", i), 32'(a_q), 32'(dn_q[i]));
      chk($sformatf("dn%0d_idx", i), 32'(a_idx), 32'(dn_idx[i]));
      chk($sformatf("dn%0d_wrap", i), 32'(a_wrap), (i == 0) ? 32'd1 : 32'd0);
    end

    // A: illegal code recovery
    a_en = 1'b0;
    edge1();
    force dut_a.q_q = 4'b0101;
    #1;
    release dut_a.q_q;
    a_dir = 1'b1;
    a_en = 1'b1;
    edge1();
    chk("flt_q", 32'(a_q), 32'h0);
    chk("flt_fault", 32'(a_fault), 32'd1);
    chk("flt_wrap", 32'(a_wrap), 32'd0);
    edge1();
    chk("flt2_q", 32'(a_q), 32'h1);
    chk("flt2_fault", 32'(a_fault), 32'd0);

    // B: prescale 3 with en gaps
    b_en = 1'b1;
    edge1(); chk_b("b1", 5'b00000, 4'd0, 1'b0);
    edge1(); chk_b("b2", 5'b00000, 4'd0, 1'b0);
    edge1(); chk_b("b3", 5'b00001, 4'd1, 1'b1);
    edge1(); chk_b("b4", 5'b00001, 4'd1, 1'b0);
    b_en = 1'b0;
    edge1(); chk_b("b5", 5'b00001, 4'd1, 1'b0);
    edge1(); chk_b("b6", 5'b00001, 4'd1, 1'b0);
    chk("b6_cnt", 32'(dut_b.u_timebase.cnt_q), 32'd1);
    b_en = 1'b1;
    edge1(); chk_b("b7", 5'b00001, 4'd1, 1'b0);
    edge1(); chk_b("b8", 5'b00011, 4'd2, 1'b1);
    edge1(); edge1();
    // en low on the would-wrap edge
    b_en = 1'b0;
    edge1(); chk_b("b11", 5'b00011, 4'd2, 1'b0);
    b_en = 1'b1;
    edge1(); chk_b("b12", 5'b00111, 4'd3, 1'b1);
    for (int i = 0; i < 6; i++) edge1();
    chk_b("b18", 5'b11111, 4'd5, 1'b1);

    // B: clear on a step edge at index 5
    edge1(); edge1();
    b_clear = 1'b1;
    edge1();
    chk_b("clr", 5'b00000, 4'd0, 1'b0);
    chk("clr_wrap", 32'(b_wrap), 32'd0);
    b_clear = 1'b0;
    edge1(); chk_b("clr1", 5'b00000, 4'd0, 1'b0);
    edge1(); chk_b("clr2", 5'b00000, 4'd0, 1'b0);
    edge1(); chk_b("clr3", 5'b00001, 4'd1, 1'b1);

    // B: async reset at q=00111 right after its step
    for (int i = 0; i < 6; i++) edge1();
    chk_b("pre_rst", 5'b00111, 4'd3, 1'b1);
    b_rst_n = 1'b0;
    #1;
    chk_b("async_rst", 5'b00000, 4'd0, 1'b0);
    #1;
    b_rst_n = 1'b1;
    edge1(); chk_b("rel1", 5'b00000, 4'd0, 1'b0);
    edge1(); chk_b("rel2", 5'b00000, 4'd0, 1'b0);
    edge1(); chk_b("rel3", 5'b00001, 4'd1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/johnson_counter_param.md
# johnson_counter_param

Parametrised, self-clocked Johnson (twisted-ring) counter for board-level display and sequencing. An internal prescaler produces a step strobe, so the whole block runs on the board clock with no derived clocks. The block adds width generalisation, run-time up/down direction, synchronous clear, a step index output and recovery from illegal ring states. It sits directly under a board top level, driving LEDs or downstream sequencers.

## Interface
- WIDTH, 4, ring width in bits; legal range ≥2; sequence length is 2·WIDTH
- PRESCALE, 16777216, clk cycles per step; legal range ≥1; 1 means step every enabled cycle
- clk  input  1  board clock; all state updates on its rising edge
- reset_n  input  1  asynchronous, active-low reset
- en  input  1  count enable; low freezes the prescaler and the ring
- dir  input  1  1 = up, 0 = down; sampled on the step edge
- clear  input  1  synchronous clear of ring and prescaler
- q  output  WIDTH  Johnson code, registered
- step_idx  output  $clog2(2·WIDTH)  position in sequence (0..2·WIDTH−1), registered
- tick  output  1  one-cycle pulse coincident with each new q
- wrap  output  1  one-cycle pulse on a step crossing between index 2·WIDTH−1 and index 0, in either direction
- fault  output  1  one-cycle pulse when an illegal q was replaced

## Operation
- Up step: q ← {q[WIDTH−2:0], ~q[WIDTH−1]}. For WIDTH=4 the sequence is 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000.
- Down step: q ← {~q[0], q[WIDTH−1:1]}. This is the exact reverse sequence; from 0000 it goes to 1000.
- step_idx:
  - q==0 → 0
  - q[0]==1 → popcount(q)
  - otherwise → 2·WIDTH − popcount(q)
- Legal code: at most one adjacent-bit transition across q[WIDTH−1:0].
- Illegal q:
  - The next step edge loads 0 instead of shifting.
  - fault pulses on that edge.
  - wrap stays low.
- Prescaler:
  - Counts 0..PRESCALE−1 while en=1.
  - On the cycle where it equals PRESCALE−1, it returns to 0 and the ring steps.
  - It holds its value while en=0.
- Priority, highest first: reset_n, clear, step.
- clear:
  - Sets q=0 and prescaler=0.
  - Forces tick, wrap and fault to 0 on that edge.
  - Applies regardless of en.
- dir may change at any time. Only the value present on the step edge matters.

## Timing
- Reset values: q=0, step_idx=0, tick=0, wrap=0, fault=0, prescaler=0.
- Reset takes effect asynchronously on the falling edge of reset_n. Release is synchronous to clk; the first step occurs PRESCALE enabled cycles after release.
- Reset or clear asserted mid-count discards the partial prescale count.
- tick, wrap and fault are registered. Each is high for exactly one cycle, the cycle in which the new q is first visible.
- step_idx is registered together with q, with zero relative latency.
- Step period is exactly PRESCALE clk cycles while en is held high. With PRESCALE=1, tick is continuously high while en=1.
- en deasserted on the edge where the prescaler would wrap: no step and no tick. The count resumes from PRESCALE−1 when en returns.

## Structure
- Shared package johnson_pkg holds:
  - DIR_UP=1'b1 and DIR_DOWN=1'b0
  - a function for step_idx from q
  - a function for the legal-code check
- One sub-module, timebase_tick:
  - parameter PRESCALE
  - ports clk, reset_n, en, clear, tick_o
  - $clog2-sized counter, minimum 1 bit
- The ring, index, wrap and fault logic live in johnson_counter_param.

## Test plan
- WIDTH=4, PRESCALE=1, dir=1, en=1 for 8 cycles → q 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; step_idx 1..7 then 0; wrap high only with the final 0000.
- WIDTH=4, PRESCALE=1, dir=0 from reset → q 1000, 1100, 1110, 1111 with step_idx 7, 6, 5, 4; wrap high only on the first step (0→7).
- WIDTH=5, PRESCALE=3, en toggled low for 2 cycles mid-count → each tick exactly 3 enabled cycles apart; q and prescaler frozen while en=0.
- clear asserted at step_idx=5 on a step edge → q=0, step_idx=0, no tick; next tick arrives PRESCALE cycles later.
- Force q=0101 (WIDTH=4), en=1 → next step edge gives q=0000 and fault=1 for one cycle; the following step gives 0001.
- reset_n dropped asynchronously mid-prescale at q=0111 → outputs go to 0 immediately, without waiting for a clk edge; after release, the first tick comes PRESCALE cycles later.
